iq_scheduler: RTL and testbench

- Issue-queue scheduler between the Rename Queue and the execute stage of the out-of-order pipeline.
- Buffers renamed instructions and tracks source-operand readiness by snooping writeback tag broadcasts.
- Each cycle it selects the oldest ready entry and presents it on a single issue port with a stall handshake.
- Drives the STALL_IQRQ back-pressure signal toward RQ.

---
 rtl/iq_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_iq_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_scheduler.sv
// iq_scheduler -- issue queue between the Rename Queue (RQ) and execute.
//
// A collapsing queue of renamed instructions: entry 0 is always the oldest and
// valid entries are packed from index 0, so "valid" is simply index < count.
// Writeback tag broadcasts wake source operands. Each cycle the oldest entry
// with both sources ready is moved into a single issue register, which holds
// under STALL_IN_EX.
//
// Optional build macro SCHED_WB_BYPASS_EN: when defined, select also treats a
// source as ready if it matches the writeback tag of the current cycle, which
// saves one cycle of wakeup-to-issue latency.
//
// Ports:
//   CLK, RESET (async, active-low), FLUSH (sync clear of queue + issue reg)
//   disp_*        : dispatch from RQ (payload, src tags/ready, dst tag)
//   STALL_OUT_RQ  : queue full, RQ must hold its instruction
//   wb_valid/tag  : writeback tag broadcast
//   STALL_IN_EX   : execute cannot accept the issue register this cycle
//   issue_*       : issue register (valid, payload, dst tag)
//   count         : occupied queue entries, issue register excluded
module iq_scheduler #(
  parameter  int DEPTH     = 8,
  parameter  int TAG_W     = 6,
  parameter  int PAYLOAD_W = 64,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 disp_valid,
  input  logic [PAYLOAD_W-1:0] disp_payload,
  input  logic [TAG_W-1:0]     disp_src1_tag,
  input  logic                 disp_src1_rdy,
  input  logic [TAG_W-1:0]     disp_src2_tag,
  input  logic                 disp_src2_rdy,
  input  logic [TAG_W-1:0]     disp_dst_tag,
  output logic                 STALL_OUT_RQ,
  input  logic                 wb_valid,
  input  logic [TAG_W-1:0]     wb_tag,
  input  logic                 STALL_IN_EX,
  output logic                 issue_valid,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [TAG_W-1:0]     issue_dst_tag,
  output logic [CW-1:0]        count
);

  // Queue entry storage (validity is implied by r_count)
  logic [PAYLOAD_W-1:0] r_pay   [DEPTH];
  logic [TAG_W-1:0]     r_s1tag [DEPTH];
  logic [TAG_W-1:0]     r_s2tag [DEPTH];
  logic [TAG_W-1:0]     r_dst   [DEPTH];
  logic [DEPTH-1:0]     r_s1rdy;
  logic [DEPTH-1:0]     r_s2rdy;

  logic [CW-1:0]        r_count;
  logic                 r_iss_vld;
  logic [PAYLOAD_W-1:0] r_iss_pay;
  logic [TAG_W-1:0]     r_iss_dst;

  logic [PAYLOAD_W-1:0] w_pay_n   [DEPTH];
  logic [TAG_W-1:0]     w_s1tag_n [DEPTH];
  logic [TAG_W-1:0]     w_s2tag_n [DEPTH];
  logic [TAG_W-1:0]     w_dst_n   [DEPTH];
  logic [DEPTH-1:0]     w_s1rdy_n;
  logic [DEPTH-1:0]     w_s2rdy_n;

  logic [DEPTH-1:0]     w_s1_sel;
  logic [DEPTH-1:0]     w_s2_sel;
  logic [DEPTH-1:0]     w_cand;
  logic [IW-1:0]        w_win;
  logic                 w_any;
  logic                 w_load;
  logic                 w_remove;
  logic                 w_full;
  logic                 w_accept;
  logic [CW-1:0]        w_widx;
  logic [CW-1:0]        w_count_n;

  // Full flag comes from registered count only; it stays up for a cycle even
  // when an entry leaves in the same cycle.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_accept     = disp_valid && !w_full;
  assign w_load       = !r_iss_vld || !STALL_IN_EX;
  assign w_remove     = w_load && w_any;
  assign w_widx       = r_count - CW'(w_remove);
  assign w_count_n    = r_count + CW'(w_accept) - CW'(w_remove);

  // Select: oldest (lowest index) entry with both sources ready
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SCHED_WB_BYPASS_EN
      w_s1_sel[i] = r_s1rdy[i] || (wb_valid && (wb_tag == r_s1tag[i]));
      w_s2_sel[i] = r_s2rdy[i] || (wb_valid && (wb_tag == r_s2tag[i]));
`else
      w_s1_sel[i] = r_s1rdy[i];
      w_s2_sel[i] = r_s2rdy[i];
`endif
      w_cand[i] = (i < int'(r_count)) && w_s1_sel[i] && w_s2_sel[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win = IW'(i);
        w_any = 1'b1;
      end
    end
  end

  // Next queue image: collapse over the winner, apply wakeup, then insert the
  // dispatched instruction at the (post-collapse) tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_remove && (i >= int'(w_win))) begin
        w_pay_n[i]   = r_pay[(i < DEPTH - 1) ? i + 1 : i];
        w_s1tag_n[i] = r_s1tag[(i < DEPTH - 1) ? i + 1 : i];
        w_s2tag_n[i] = r_s2tag[(i < DEPTH - 1) ? i + 1 : i];
        w_dst_n[i]   = r_dst[(i < DEPTH - 1) ? i + 1 : i];
        w_s1rdy_n[i] = r_s1rdy[(i < DEPTH - 1) ? i + 1 : i];
        w_s2rdy_n[i] = r_s2rdy[(i < DEPTH - 1) ? i + 1 : i];
      end else begin
        w_pay_n[i]   = r_pay[i];
        w_s1tag_n[i] = r_s1tag[i];
        w_s2tag_n[i] = r_s2tag[i];
        w_dst_n[i]   = r_dst[i];
        w_s1rdy_n[i] = r_s1rdy[i];
        w_s2rdy_n[i] = r_s2rdy[i];
      end
      w_s1rdy_n[i] = w_s1rdy_n[i] || (wb_valid && (wb_tag == w_s1tag_n[i]));
      w_s2rdy_n[i] = w_s2rdy_n[i] || (wb_valid && (wb_tag == w_s2tag_n[i]));
      if (w_accept && (i == int'(w_widx))) begin
        w_pay_n[i]   = disp_payload;
        w_s1tag_n[i] = disp_src1_tag;
        w_s2tag_n[i] = disp_src2_tag;
        w_dst_n[i]   = disp_dst_tag;
        w_s1rdy_n[i] = disp_src1_rdy || (wb_valid && (wb_tag == disp_src1_tag));
        w_s2rdy_n[i] = disp_src2_rdy || (wb_valid && (wb_tag == disp_src2_tag));
      end
    end
  end

  // Entry data: no reset needed, r_count alone decides which entries are live
  always_ff @(posedge CLK) begin
    r_pay   <= w_pay_n;
    r_s1tag <= w_s1tag_n;
    r_s2tag <= w_s2tag_n;
    r_dst   <= w_dst_n;
    r_s1rdy <= w_s1rdy_n;
    r_s2rdy <= w_s2rdy_n;
  end

  // Occupancy and issue register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count   <= '0;
      r_iss_vld <= 1'b0;
      r_iss_pay <= '0;
      r_iss_dst <= '0;
    end else if (FLUSH) begin
      r_count   <= '0;
      r_iss_vld <= 1'b0;
    end else begin
      r_count <= w_count_n;
      if (w_load) begin
        r_iss_vld <= w_any;
        if (w_any) begin
          r_iss_pay <= r_pay[w_win];
          r_iss_dst <= r_dst[w_win];
        end
      end
    end
  end

  assign STALL_OUT_RQ  = w_full;
  assign issue_valid   = r_iss_vld;
  assign issue_payload = r_iss_pay;
  assign issue_dst_tag = r_iss_dst;
  assign count         = r_count;

endmodule

// File: tb/tb_iq_scheduler.sv
module tb_iq_scheduler;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PW    = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          FLUSH = 1'b0;
  logic          disp_valid = 1'b0;
  logic [PW-1:0] disp_payload = '0;
  logic [TAG_W-1:0] disp_src1_tag = '0, disp_src2_tag = '0, disp_dst_tag = '0;
  logic          disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
  logic          STALL_OUT_RQ;
  logic          wb_valid = 1'b0;
  logic [TAG_W-1:0] wb_tag = '0;
  logic          STALL_IN_EX = 1'b0;
  logic          issue_valid;
  logic [PW-1:0] issue_payload;
  logic [TAG_W-1:0] issue_dst_tag;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;
  int exp_dst[$];
  logic [PW-1:0] exp_pay[$];

  iq_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .STALL_OUT_RQ(STALL_OUT_RQ),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .STALL_IN_EX(STALL_IN_EX),
    .issue_valid(issue_valid), .issue_payload(issue_payload),
    .issue_dst_tag(issue_dst_tag), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [PW-1:0] pay(input int d);
    return 64'hC0DE_0000_0000_0000 | 64'(d);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input int dst, input int t1, input logic r1,
                      input int t2, input logic r2);
    disp_valid    = 1'b1;
    disp_payload  = pay(dst);
    disp_dst_tag  = TAG_W'(dst);
    disp_src1_tag = TAG_W'(t1);
    disp_src1_rdy = r1;
    disp_src2_tag = TAG_W'(t2);
    disp_src2_rdy = r2;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = 1'b0;
  endtask

  task automatic expect_issue(input int dst);
    exp_dst.push_back(dst);
    exp_pay.push_back(pay(dst));
  endtask

  // Monitor: an issue is consumed at the next edge when valid and not stalled
  always @(negedge CLK) begin
    if (RESET && !FLUSH && issue_valid && !STALL_IN_EX) begin
      if (exp_dst.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue: got dst %0d, expected none", issue_dst_tag);
      end else begin
        chk("issue_dst", 64'(issue_dst_tag), 64'(exp_dst.pop_front()));
        chk("issue_payload", issue_payload, exp_pay.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_issue_valid", 64'(issue_valid), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_stall", 64'(STALL_OUT_RQ), 0);
    chk("rst_payload", issue_payload, 0);
    chk("rst_dst", 64'(issue_dst_tag), 0);
    step();
    RESET = 1'b1;
    step();

    // Single ready instruction: issue one edge after dispatch
    disp(5, 1, 1'b1, 2, 1'b1);
    expect_issue(5);
    step();
    idle();
    chk("t1_count_after_disp", 64'(count), 1);
    chk("t1_issue_valid_early", 64'(issue_valid), 0);
    step();
    chk("t1_issue_valid", 64'(issue_valid), 1);
    chk("t1_issue_dst", 64'(issue_dst_tag), 5);
    chk("t1_count_drained", 64'(count), 0);
    step();
    chk("t1_idle", 64'(issue_valid), 0);

    // Younger ready instruction bypasses an older waiting one
    disp(10, 9, 1'b0, 3, 1'b1);
    step();
    disp(11, 1, 1'b1, 2, 1'b1);
    expect_issue(11);
    expect_issue(10);
    step();
    idle();
    step();
    chk("t2_b_first", 64'(issue_dst_tag), 11);
    chk("t2_count", 64'(count), 1);
    wb_valid = 1'b1;
    wb_tag   = 6'd9;
    step();
    idle();
`ifndef SCHED_WB_BYPASS_EN
    chk("t2_gap_valid", 64'(issue_valid), 0);
    step();
`endif
    chk("t2_a_valid", 64'(issue_valid), 1);
    chk("t2_a_dst", 64'(issue_dst_tag), 10);
    chk("t2_count_empty", 64'(count), 0);
    step();

    // Fill the queue with waiting entries
    for (int i = 0; i < DEPTH; i++) begin
      disp(30 + i, 20 + i, 1'b0, 1, 1'b1);
      step();
    end
    idle();
    chk("t3_count_full", 64'(count), DEPTH);
    chk("t3_stall_full", 64'(STALL_OUT_RQ), 1);
    disp(40, 1, 1'b1, 2, 1'b1);
    step();
    idle();
    chk("t3_ninth_dropped", 64'(count), DEPTH);
    wb_valid = 1'b1;
    wb_tag   = 6'd23;
    expect_issue(33);
    step();
    idle();
`ifndef SCHED_WB_BYPASS_EN
    step();
`endif
    chk("t3_e3_valid", 64'(issue_valid), 1);
    chk("t3_e3_dst", 64'(issue_dst_tag), 33);
    chk("t3_count_7", 64'(count), 7);
    chk("t3_stall_clear", 64'(STALL_OUT_RQ), 0);

    // Execute stall holds the issue register; wakeups happen meanwhile
    STALL_IN_EX = 1'b1;
    for (int c = 0; c < 4; c++) begin
      wb_valid = (c < 2);
      wb_tag   = TAG_W'(20 + c);
      step();
      chk("t4_hold_dst", 64'(issue_dst_tag), 33);
      chk("t4_hold_payload", issue_payload, pay(33));
      chk("t4_hold_count", 64'(count), 7);
    end
    idle();
    STALL_IN_EX = 1'b0;
    expect_issue(30);
    step();
    chk("t4_release_dst", 64'(issue_dst_tag), 30);
    chk("t4_release_count", 64'(count), 6);
    step();
    chk("t4_next_dst", 64'(issue_dst_tag), 31);
    chk("t4_next_count", 64'(count), 5);
    STALL_IN_EX = 1'b1;

    // Flush with 5 entries and a held issue; the concurrent dispatch is dropped
    FLUSH = 1'b1;
    disp(50, 1, 1'b1, 2, 1'b1);
    step();
    idle();
    FLUSH = 1'b0;
    STALL_IN_EX = 1'b0;
    chk("t5_flush_count", 64'(count), 0);
    chk("t5_flush_valid", 64'(issue_valid), 0);
    step();
    step();
    chk("t5_after_valid", 64'(issue_valid), 0);
    chk("t5_after_count", 64'(count), 0);

    // Dispatch-time writeback capture
    disp(44, 1, 1'b1, 12, 1'b0);
    wb_valid = 1'b1;
    wb_tag   = 6'd12;
    expect_issue(44);
    step();
    idle();
    chk("t6_count", 64'(count), 1);
    step();
    chk("t6_valid", 64'(issue_valid), 1);
    chk("t6_dst", 64'(issue_dst_tag), 44);
    chk("t6_count_empty", 64'(count), 0);
    step();

    // Asynchronous reset mid-stream
    disp(46, 60, 1'b0, 1, 1'b1);
    step();
    disp(47, 61, 1'b0, 1, 1'b1);
    step();
    disp(45, 1, 1'b1, 2, 1'b1);
    step();
    idle();
    step();
    chk("t7_pre_valid", 64'(issue_valid), 1);
    chk("t7_pre_dst", 64'(issue_dst_tag), 45);
    STALL_IN_EX = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    chk("t7_async_valid", 64'(issue_valid), 0);
    chk("t7_async_count", 64'(count), 0);
    chk("t7_async_payload", issue_payload, 0);
    chk("t7_async_dst", 64'(issue_dst_tag), 0);
    STALL_IN_EX = 1'b0;
    step();
    RESET = 1'b1;
    wb_valid = 1'b1;
    wb_tag   = 6'd60;
    step();
    idle();
    step();
    step();
    chk("t7_no_stale_valid", 64'(issue_valid), 0);
    chk("t7_no_stale_count", 64'(count), 0);

    chk("scoreboard_drained", 64'(exp_dst.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
